// File: rtl/memory_board_ctrl.sv
// ============================================================================
// Module : memory_board_ctrl
// Brief  : Two-player memory-game board controller with pair matching,
//          per-pick turn timer, scoring and end-of-game detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memory_board_ctrl #(
  parameter int NUM_TILES   = 16,
  parameter int LABEL_W     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int TURN_CYCLES = 100,
  parameter int SCORE_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_TILES*LABEL_W-1:0]   labels_i,
  input  logic [$clog2(NUM_TILES)-1:0]   cursor_idx_i,
  input  logic                           select_i,
  output logic [2*NUM_TILES-1:0]         tile_state_o,
  output logic                           player_o,
  output logic [SCORE_W-1:0]             score0_o,
  output logic [SCORE_W-1:0]             score1_o,
  output logic                           match_p_o,
  output logic                           mismatch_p_o,
  output logic                           timeout_p_o,
  output logic                           game_over_o
);

  localparam int IW = $clog2(NUM_TILES);
  localparam int TW = $clog2(TURN_CYCLES);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IW:0]   NT_C   = NUM_TILES[IW:0];
  localparam logic [TW-1:0] TMAX_C = TW'(TURN_CYCLES - 1);
  localparam logic [HW-1:0] HMAX_C = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PICK1   = 3'd0,
    S_PICK2   = 3'd1,
    S_SHOW    = 3'd2,
    S_RESOLVE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_TILES-1:0]   revealed_q, revealed_d;
  logic [NUM_TILES-1:0]   matched_q, matched_d;
  logic [IW-1:0]          idx1_q, idx1_d;
  logic [IW-1:0]          idx2_q, idx2_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   player_q, player_d;
  logic [SCORE_W-1:0]     score0_q, score0_d;
  logic [SCORE_W-1:0]     score1_q, score1_d;
  logic                   match_q, match_d;
  logic                   mismatch_q, mismatch_d;
  logic                   timeout_q, timeout_d;

  logic w_in_range, w_pick_ok, w_expire, w_cursor_on, w_labels_eq;

  assign w_in_range  = ({1'b0, cursor_idx_i} < NT_C);
  assign w_pick_ok   = select_i && w_in_range &&
                       !revealed_q[cursor_idx_i] && !matched_q[cursor_idx_i];
  assign w_expire    = (timer_q == TMAX_C);
  assign w_cursor_on = (state_q == S_PICK1) || (state_q == S_PICK2);
  assign w_labels_eq = (labels_i[idx1_q*LABEL_W +: LABEL_W] ==
                        labels_i[idx2_q*LABEL_W +: LABEL_W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PICK1;
      revealed_q <= '0;
      matched_q  <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      timer_q    <= '0;
      hold_q     <= '0;
      player_q   <= 1'b0;
      score0_q   <= '0;
      score1_q   <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      revealed_q <= revealed_d;
      matched_q  <= matched_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      player_q   <= player_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    revealed_d = revealed_q;
    matched_d  = matched_q;
    idx1_d     = idx1_q;
    idx2_d     = idx2_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    player_d   = player_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_PICK1: begin
        // A valid pick takes priority over a coincident timer expiry.
        if (w_pick_ok) begin
          revealed_d[cursor_idx_i] = 1'b1;
          idx1_d  = cursor_idx_i;
          timer_d = '0;
          state_d = S_PICK2;
        end else if (w_expire) begin
          timeout_d = 1'b1;
          player_d  = ~player_q;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PICK2: begin
        if (w_pick_ok && (cursor_idx_i != idx1_q)) begin
          revealed_d[cursor_idx_i] = 1'b1;
          idx2_d  = cursor_idx_i;
          hold_d  = '0;
          timer_d = '0;
          state_d = S_SHOW;
        end else if (w_expire) begin
          timeout_d          = 1'b1;
          revealed_d[idx1_q] = 1'b0;
          player_d           = ~player_q;
          timer_d            = '0;
          state_d            = S_PICK1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (hold_q == HMAX_C) state_d = S_RESOLVE;
        else                  hold_d  = hold_q + 1'b1;
      end
      S_RESOLVE: begin
        revealed_d[idx1_q] = 1'b0;
        revealed_d[idx2_q] = 1'b0;
        if (w_labels_eq) begin
          matched_d[idx1_q] = 1'b1;
          matched_d[idx2_q] = 1'b1;
          match_d           = 1'b1;
          if (!player_q && (score0_q != '1)) score0_d = score0_q + 1'b1;
          if (player_q  && (score1_q != '1)) score1_d = score1_q + 1'b1;
        end else begin
          mismatch_d = 1'b1;
          player_d   = ~player_q;
        end
        timer_d = '0;
        state_d = (&matched_d) ? S_DONE : S_PICK1;
      end
      S_DONE: ;
      default: state_d = S_PICK1;
    endcase
  end

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_tile
    assign tile_state_o[2*i +: 2] =
      matched_q[i]  ? 2'b11 :
      revealed_q[i] ? 2'b10 :
      (w_cursor_on && (cursor_idx_i == IW'(i))) ? 2'b01 : 2'b00;
  end

  assign player_o     = player_q;
  assign score0_o     = score0_q;
  assign score1_o     = score1_q;
  assign match_p_o    = match_q;
  assign mismatch_p_o = mismatch_q;
  assign timeout_p_o  = timeout_q;
  assign game_over_o  = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_memory_board_ctrl.sv
// ============================================================================
// Module : tb_memory_board_ctrl
// Brief  : Directed self-checking bench for memory_board_ctrl (6-tile board
//          with out-of-range cursor codes, plus a 4-tile 1-bit-score board).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_memory_board_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  logic [23:0] labels;
  logic [2:0]  cur;
  logic        sel;
  logic [11:0] ts;
  logic        player, mp, mmp, top, go;
  logic [3:0]  sc0, sc1;

  logic [15:0] labels_s;
  logic [1:0]  cur_s;
  logic        sel_s;
  logic [7:0]  ts_s;
  logic        player_s, mp_s, mmp_s, top_s, go_s;
  logic [0:0]  sc0_s, sc1_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_board_ctrl #(
    .NUM_TILES(6), .LABEL_W(4), .HOLD_CYCLES(4), .TURN_CYCLES(20), .SCORE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .labels_i(labels), .cursor_idx_i(cur), .select_i(sel),
    .tile_state_o(ts), .player_o(player), .score0_o(sc0), .score1_o(sc1),
    .match_p_o(mp), .mismatch_p_o(mmp), .timeout_p_o(top), .game_over_o(go)
  );

  memory_board_ctrl #(
    .NUM_TILES(4), .LABEL_W(4), .HOLD_CYCLES(2), .TURN_CYCLES(20), .SCORE_W(1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .labels_i(labels_s), .cursor_idx_i(cur_s), .select_i(sel_s),
    .tile_state_o(ts_s), .player_o(player_s), .score0_o(sc0_s), .score1_o(sc1_s),
    .match_p_o(mp_s), .mismatch_p_o(mmp_s), .timeout_p_o(top_s), .game_over_o(go_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] tile(input int i);
    return ts[2*i +: 2];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pick(input int idx);
    cur = 3'(idx);
    sel = 1'b1;
    step(1);
    sel = 1'b0;
  endtask

  task automatic spick(input int idx);
    cur_s = 2'(idx);
    sel_s = 1'b1;
    step(1);
    sel_s = 1'b0;
  endtask

  initial begin
    // tile labels: 0:3 1:2 2:7 3:1 4:1 5:3
    labels   = {4'd3, 4'd1, 4'd1, 4'd7, 4'd2, 4'd3};
    // small board pairs: {0,2}=5, {1,3}=6
    labels_s = {4'd6, 4'd5, 4'd6, 4'd5};
    rst = 1'b1; rst_s = 1'b1;
    cur = 3'd7; sel = 1'b0; cur_s = 2'd0; sel_s = 1'b0;
    step(2);
    chk("reset_tiles", 32'(ts), 32'h0);
    chk("reset_player", 32'(player), 32'h0);
    chk("reset_scores", 32'({sc0, sc1}), 32'h0);
    chk("reset_pulses", 32'({mp, mmp, top, go}), 32'h0);

    // async reset in the middle of SHOW
    rst = 1'b0;
    pick(0);
    pick(1);
    chk("show_t0", 32'(tile(0)), 32'h2);
    chk("show_t1", 32'(tile(1)), 32'h2);
    cur = 3'd7;
    #3 rst = 1'b1;
    #1;
    chk("midreset_tiles", 32'(ts), 32'h0);
    chk("midreset_player_scores", 32'({player, sc0, sc1}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cur = 3'd2;
    #1;
    chk("midreset_pick1_cursor", 32'(tile(2)), 32'h1);

    // matching pair 0/5 for player 0
    pick(0);
    chk("m_t0_rev", 32'(tile(0)), 32'h2);
    pick(5);
    chk("m_t5_rev", 32'(tile(5)), 32'h2);
    cur = 3'd3; sel = 1'b1;
    step(1);
    sel = 1'b0;
    chk("show_ignores_select", 32'(tile(3)), 32'h0);
    step(3);
    chk("m_hold_end", 32'({tile(0), tile(5)}), 32'hA);
    chk("m_no_pulse_yet", 32'(mp), 32'h0);
    step(1);
    chk("m_matched", 32'({tile(0), tile(5)}), 32'hF);
    chk("m_match_p", 32'({mp, mmp}), 32'h2);
    chk("m_score0", 32'(sc0), 32'h1);
    chk("m_player", 32'(player), 32'h0);
    step(1);
    chk("m_match_p_clear", 32'(mp), 32'h0);

    // mismatch 1/2
    pick(1);
    pick(2);
    step(4);
    chk("mm_hold_end", 32'({tile(1), tile(2)}), 32'hA);
    cur = 3'd7;
    step(1);
    chk("mm_hidden", 32'({tile(1), tile(2)}), 32'h0);
    chk("mm_pulse", 32'({mp, mmp}), 32'h1);
    chk("mm_player", 32'(player), 32'h1);
    chk("mm_scores", 32'({sc0, sc1}), 32'h10);
    step(1);
    chk("mm_pulse_clear", 32'(mmp), 32'h0);

    // invalid picks in PICK2
    pick(3);
    chk("inv_first", 32'(tile(3)), 32'h2);
    pick(3);
    pick(0);
    pick(7);
    pick(6);
    chk("inv_matched_kept", 32'(tile(0)), 32'h3);
    cur = 3'd4;
    #1;
    chk("inv_still_pick2", 32'({tile(3), tile(4)}), 32'h9);
    pick(4);
    step(4);
    cur = 3'd7;
    step(1);
    chk("p1_match_tiles", 32'({tile(3), tile(4)}), 32'hF);
    chk("p1_score1", 32'({sc0, sc1}), 32'h11);
    chk("p1_player_kept", 32'({player, mp}), 32'h3);

    // PICK2 timeout, PICK1 timeout, then pick coincident with expiry
    pick(1);
    cur = 3'd7;
    step(19);
    chk("to2_before", 32'({tile(1), top}), 32'h4);
    step(1);
    chk("to2_hidden", 32'(tile(1)), 32'h0);
    chk("to2_pulse_player", 32'({top, player}), 32'h2);
    step(1);
    chk("to2_pulse_clear", 32'(top), 32'h0);
    step(18);
    chk("to1_before", 32'({top, player}), 32'h0);
    step(1);
    chk("to1_pulse_player", 32'({top, player}), 32'h3);
    step(19);
    pick(2);
    chk("coincide_pick", 32'(tile(2)), 32'h2);
    chk("coincide_no_timeout", 32'({top, player}), 32'h1);

    // small board: two matches for player 0, 1-bit saturating score
    rst_s = 1'b0;
    spick(0);
    spick(2);
    step(2);
    chk("s_hold", 32'(ts_s[5:4]), 32'h2);
    step(1);
    chk("s_first_match", 32'({sc0_s, mp_s, go_s, player_s}), 32'hC);
    spick(1);
    spick(3);
    step(3);
    chk("s_all_matched", 32'(ts_s), 32'hFF);
    chk("s_saturated_over", 32'({sc0_s, mp_s, go_s, player_s}), 32'hE);
    cur_s = 2'd1; sel_s = 1'b1;
    step(1);
    sel_s = 1'b0;
    chk("s_done_ignores", 32'({ts_s, sc0_s, mp_s, go_s}), 32'h7FD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
